router_pkt_src: RTL and testbench
=================================

ROUTER_PKT_SRC -- requirements
Module: router_pkt_src

Interface
REQ-001 Parameter LFSR_SEED, 8'hA5, payload LFSR reset value; 8'h00 SHALL be replaced by 8'h01.
REQ-002 clock  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request one packet; sampled only in IDLE.
REQ-005 cfg_addr  input  2  destination port 0..2; latched on accepted start.
REQ-006 cfg_len  input  6  payload byte count 1..63; latched on accepted start.
REQ-007 busy  input  1  router stall; high = current byte not accepted this edge.
REQ-008 data_in  output  8  registered packet byte to router.
REQ-009 pkt_valid  output  1  registered; high for header and payload, low for parity byte.
REQ-010 ready  output  1  high only in IDLE.
REQ-011 done  output  1  one-cycle pulse after parity byte accepted.
REQ-012 bad_cfg  output  1  one-cycle pulse when start rejected.

Function
REQ-013 States SHALL be IDLE, PAYLOAD, PARITY; bus content follows state.
REQ-014 IDLE: start with cfg_addr!=3 and cfg_len!=0 SHALL, at that edge, load data_in={cfg_len,cfg_addr}, pkt_valid=1, parity=header, cnt=0, go PAYLOAD (header on bus 1 cycle after start).
REQ-015 IDLE: start with cfg_addr==3 or cfg_len==0 SHALL pulse bad_cfg next cycle, remain IDLE, leave pkt_valid=0.
REQ-016 PAYLOAD, busy=0, cnt<len: data_in<=LFSR value, parity^=that value, LFSR advances, cnt++.
REQ-017 PAYLOAD, busy=0, cnt==len: data_in<=parity, pkt_valid<=0, go PARITY.
REQ-018 PARITY, busy=0: data_in<=0, done pulse, go IDLE; next start accepted the following cycle.
REQ-019 busy=1 in any non-IDLE state SHALL hold data_in, pkt_valid, state, cnt, parity, LFSR unchanged.
REQ-020 start outside IDLE SHALL be ignored with no bad_cfg.
REQ-021 LFSR: 8-bit Galois, mask 8'hB8, shift right, advances only per issued payload byte, never reset between packets.
REQ-022 With busy=0 throughout a packet occupies len+2 bus cycles; pkt_valid high exactly len+1 of them.
REQ-023 parity SHALL equal XOR of header and all payload bytes, 8-bit.

Reset
REQ-024 reset SHALL immediately force IDLE, data_in=0, pkt_valid=0, done=0, bad_cfg=0, cnt=0, parity=0, LFSR=LFSR_SEED, ready=1.
REQ-025 reset mid-packet SHALL abandon the packet; no done pulse.

Configuration
REQ-026 Macro ROUTER_PKT_SRC_PARITY_ERR_EN defined: extra input inject_err (1 bit) latched on accepted start; if set, parity byte driven as ~parity.
REQ-027 Macro undefined: no inject_err port; parity always correct.

Structure
REQ-028 Package router_pkg SHALL hold state encoding, ROUTER_MAX_ADDR=2, LFSR mask 8'hB8, header-pack function {len,addr}.
REQ-029 Sub-module router_lfsr8 (seed, advance enable, 8-bit value) SHALL hold the LFSR.

Verification
REQ-030 start, addr=0, len=17, seed A5, busy=0 -> data_in 8'h44 next cycle, 17 LFSR bytes starting 8'hA5, parity=XOR, pkt_valid high 18 cycles, done pulse.
REQ-031 busy high 3 cycles during 5th payload byte -> that byte held 4 cycles total, no byte lost or repeated, parity unchanged.
REQ-032 start with addr=3 or len=0 -> bad_cfg one cycle, pkt_valid stays 0, ready stays 1.
REQ-033 reset asserted at payload byte 8 -> outputs 0 asynchronously, IDLE; next packet len=1 begins with LFSR byte 8'hA5.
REQ-034 len=1 and len=63 back-to-back -> 3 then 65 bus cycles, second header 1 cycle after second start.
REQ-035 With ROUTER_PKT_SRC_PARITY_ERR_EN, inject_err=1 -> parity byte equals bitwise inverse of correct parity.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet source: FSM encoding,
// address limit, LFSR mask and header/LFSR helper functions.
package router_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_PARITY  = 2'd2
   } state_t;

   localparam logic [1:0] ROUTER_MAX_ADDR = 2'd2;
   localparam logic [7:0] LFSR_MASK       = 8'hB8;

   function automatic logic [7:0] pack_header(input logic [5:0] len, input logic [1:0] addr);
      return {len, addr};
   endfunction

   // Galois form, shifting right: the bit falling out of bit 0 folds the mask back in.
   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {1'b0, v[7:1]} ^ (v[0] ? LFSR_MASK : 8'h00);
   endfunction

endpackage

// File: rtl/router_lfsr8.sv
// 8-bit Galois LFSR payload generator; a zero seed is promoted to 8'h01 so the
// register can never lock up in the all-zero state.
module router_lfsr8
   import router_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       advance,
   output logic [7:0] value
);

   localparam logic [7:0] SEED_FIX = (SEED == 8'h00) ? 8'h01 : SEED;

   logic [7:0] lfsr_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lfsr_reg <= SEED_FIX;
      end else if (advance) begin
         lfsr_reg <= lfsr_next(lfsr_reg);
      end
   end

   assign value = lfsr_reg;

endmodule

// File: rtl/router_pkt_src.sv
// Packet source for the router: emits header, LFSR payload and parity byte,
// honouring the router's busy stall. Optional macro ROUTER_PKT_SRC_PARITY_ERR_EN
// adds an inject_err input that inverts the parity byte of a packet.
module router_pkt_src
   import router_pkg::*;
#(
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] cfg_addr,
   input  logic [5:0] cfg_len,
   input  logic       busy,
   output logic [7:0] data_in,
   output logic       pkt_valid,
   output logic       ready,
   output logic       done,
   output logic       bad_cfg
`ifdef ROUTER_PKT_SRC_PARITY_ERR_EN
   ,
   input  logic       inject_err
`endif
);

   state_t     state_reg;
   logic [5:0] cnt_reg;
   logic [5:0] len_reg;
   logic [7:0] parity_reg;
   logic [7:0] data_reg;
   logic       valid_reg;
   logic       ready_reg;
   logic       done_reg;
   logic       bad_cfg_reg;
   logic [7:0] lfsr_value;
   logic [7:0] parity_byte;
   logic       lfsr_advance;
   logic       cfg_ok;

   assign cfg_ok = (cfg_addr <= ROUTER_MAX_ADDR) && (cfg_len != 6'd0);

   // The LFSR steps exactly when a payload byte is loaded onto the bus.
   assign lfsr_advance = (state_reg == ST_PAYLOAD) && !busy && (cnt_reg != len_reg);

   router_lfsr8 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clock   (clock),
      .reset   (reset),
      .advance (lfsr_advance),
      .value   (lfsr_value)
   );

`ifdef ROUTER_PKT_SRC_PARITY_ERR_EN
   logic inject_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         inject_reg <= 1'b0;
      end else if (state_reg == ST_IDLE && start && cfg_ok) begin
         inject_reg <= inject_err;
      end
   end

   assign parity_byte = parity_reg ^ {8{inject_reg}};
`else
   assign parity_byte = parity_reg;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= 6'd0;
         len_reg     <= 6'd0;
         parity_reg  <= 8'h00;
         data_reg    <= 8'h00;
         valid_reg   <= 1'b0;
         ready_reg   <= 1'b1;
         done_reg    <= 1'b0;
         bad_cfg_reg <= 1'b0;
      end else begin
         done_reg    <= 1'b0;
         bad_cfg_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  if (cfg_ok) begin
                     data_reg   <= pack_header(cfg_len, cfg_addr);
                     parity_reg <= pack_header(cfg_len, cfg_addr);
                     valid_reg  <= 1'b1;
                     ready_reg  <= 1'b0;
                     cnt_reg    <= 6'd0;
                     len_reg    <= cfg_len;
                     state_reg  <= ST_PAYLOAD;
                  end else begin
                     bad_cfg_reg <= 1'b1;
                  end
               end
            end
            ST_PAYLOAD: begin
               // busy means the byte on the bus was not taken; everything holds.
               if (!busy) begin
                  if (cnt_reg != len_reg) begin
                     data_reg   <= lfsr_value;
                     parity_reg <= parity_reg ^ lfsr_value;
                     cnt_reg    <= cnt_reg + 6'd1;
                  end else begin
                     data_reg  <= parity_byte;
                     valid_reg <= 1'b0;
                     state_reg <= ST_PARITY;
                  end
               end
            end
            ST_PARITY: begin
               if (!busy) begin
                  data_reg  <= 8'h00;
                  done_reg  <= 1'b1;
                  ready_reg <= 1'b1;
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               ready_reg <= 1'b1;
               valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign data_in   = data_reg;
   assign pkt_valid = valid_reg;
   assign ready     = ready_reg;
   assign done      = done_reg;
   assign bad_cfg   = bad_cfg_reg;

endmodule

// File: tb/tb_router_pkt_src.sv
// Self-checking bench for router_pkt_src: expected packets are built from a
// byte-level model (header, LFSR payload, XOR parity) and compared cycle by cycle.
module tb_router_pkt_src;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [1:0] cfg_addr = 2'd0;
   logic [5:0] cfg_len = 6'd0;
   logic       busy = 1'b0;
   logic [7:0] data_in;
   logic       pkt_valid;
   logic       ready;
   logic       done;
   logic       bad_cfg;
`ifdef ROUTER_PKT_SRC_PARITY_ERR_EN
   logic       inject_err = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   logic [7:0] model_lfsr = 8'hA5;

   router_pkt_src #(.LFSR_SEED(8'hA5)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .cfg_addr  (cfg_addr),
      .cfg_len   (cfg_len),
      .busy      (busy),
      .data_in   (data_in),
      .pkt_valid (pkt_valid),
      .ready     (ready),
      .done      (done),
      .bad_cfg   (bad_cfg)
`ifdef ROUTER_PKT_SRC_PARITY_ERR_EN
      ,
      .inject_err(inject_err)
`endif
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
   endfunction

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   // Sends one packet; hold_idx stalls that bus byte 3 extra cycles, abort_at fires reset there.
   task automatic send_pkt(input logic [1:0] addr, input logic [5:0] len, input int busy_pct,
                           input int hold_idx, input int abort_at, input bit inj);
      logic [7:0] exp_q[$];
      logic [7:0] lf;
      logic [7:0] par;
      int idx = 0;
      int cycles = 0;
      int valid_cycles = 0;
      int held = 0;
      lf  = model_lfsr;
      par = {len, addr};
      exp_q.push_back(par);
      for (int i = 0; i < int'(len); i++) begin
         exp_q.push_back(lf);
         par ^= lf;
         lf = lfsr_step(lf);
      end
      exp_q.push_back(inj ? ~par : par);

      chk("ready_before_start", ready, 1'b1);
      start = 1'b1; cfg_addr = addr; cfg_len = len;
`ifdef ROUTER_PKT_SRC_PARITY_ERR_EN
      inject_err = inj;
`endif
      next_cycle();
      start = 1'b0;
      while (idx < exp_q.size()) begin
         if (idx == abort_at) begin
            reset = 1'b1;
            #1;
            chk("abort_data", data_in, 8'h00);
            chk("abort_valid", pkt_valid, 1'b0);
            chk("abort_ready", ready, 1'b1);
            chk("abort_done", done, 1'b0);
            next_cycle();
            reset = 1'b0; busy = 1'b0; start = 1'b0;
            next_cycle();
            chk("abort_no_done", done, 1'b0);
            chk("abort_idle_valid", pkt_valid, 1'b0);
            model_lfsr = 8'hA5;
            return;
         end
         chk($sformatf("byte%0d_data", idx), data_in, exp_q[idx]);
         chk($sformatf("byte%0d_valid", idx), pkt_valid, (idx < exp_q.size() - 1) ? 1'b1 : 1'b0);
         chk("busy_ready", ready, 1'b0);
         chk("busy_done", done, 1'b0);
         chk("busy_bad_cfg", bad_cfg, 1'b0);
         cycles++;
         if (pkt_valid) valid_cycles++;
         busy = ($urandom_range(99) < busy_pct);
         if (idx == hold_idx && held < 3) begin
            busy = 1'b1;
            held++;
         end
         start = (busy_pct > 0) ? 1'($urandom_range(1)) : 1'b0;
         cfg_addr = 2'($urandom_range(3)); cfg_len = 6'($urandom_range(63));
         next_cycle();
         if (!busy) idx++;
         if (cycles > 4000) begin
            chk("packet_timeout", 32'(idx), 32'(exp_q.size()));
            break;
         end
      end
      busy = 1'b0; start = 1'b0;
      chk("done_pulse", done, 1'b1);
      chk("done_data", data_in, 8'h00);
      chk("done_valid", pkt_valid, 1'b0);
      chk("done_ready", ready, 1'b1);
      if (busy_pct == 0 && hold_idx < 0) begin
         chk("bus_cycles", 32'(cycles), 32'(len) + 2);
         chk("valid_cycles", 32'(valid_cycles), 32'(len) + 1);
      end
      if (hold_idx >= 0) chk("hold_extra_cycles", 32'(cycles), 32'(len) + 5);
      $display("pkt addr=%0d len=%0d cycles=%0d parity=%02h", addr, len, cycles, exp_q[exp_q.size()-1]);
      model_lfsr = lf;
   endtask

   task automatic send_bad(input logic [1:0] addr, input logic [5:0] len);
      start = 1'b1; cfg_addr = addr; cfg_len = len;
      next_cycle();
      start = 1'b0;
      chk("bad_cfg_pulse", bad_cfg, 1'b1);
      chk("bad_valid", pkt_valid, 1'b0);
      chk("bad_ready", ready, 1'b1);
      next_cycle();
      chk("bad_cfg_clear", bad_cfg, 1'b0);
      chk("bad_ready_after", ready, 1'b1);
      $display("bad start addr=%0d len=%0d", addr, len);
   endtask

   initial begin
      #12;
      chk("rst_data", data_in, 8'h00);
      chk("rst_valid", pkt_valid, 1'b0);
      chk("rst_ready", ready, 1'b1);
      chk("rst_done", done, 1'b0);
      chk("rst_bad_cfg", bad_cfg, 1'b0);
      next_cycle();
      reset = 1'b0;
      next_cycle();
      chk("idle_ready", ready, 1'b1);

      send_pkt(2'd0, 6'd17, 0, -1, -1, 1'b0);
      send_pkt(2'd1, 6'd10, 0, 5, -1, 1'b0);
      send_bad(2'd3, 6'd5);
      send_bad(2'd1, 6'd0);
      send_pkt(2'd2, 6'd20, 0, -1, 8, 1'b0);
      send_pkt(2'd0, 6'd1, 0, -1, -1, 1'b0);
      send_pkt(2'd1, 6'd1, 0, -1, -1, 1'b0);
      send_pkt(2'd2, 6'd63, 0, -1, -1, 1'b0);
      for (int k = 0; k < 8; k++) begin
         send_pkt(2'($urandom_range(2)), 6'($urandom_range(63, 1)), 30, -1, -1, 1'b0);
      end
`ifdef ROUTER_PKT_SRC_PARITY_ERR_EN
      send_pkt(2'd1, 6'd9, 0, -1, -1, 1'b1);
      send_pkt(2'd0, 6'd4, 0, -1, -1, 1'b0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
